// File: rtl/window_sum_5x5_if.sv
// Window-in / sum-out signal bundle for window_sum_5x5.
// The master drives windows and their centre coordinates; the slave returns aligned sums.
interface window_sum_5x5_if #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int DATA_WIDTH = 12,
  parameter int SUM_WIDTH  = DATA_WIDTH + 5
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH * HEIGHT);

  logic signed [DATA_WIDTH-1:0] window [5][5];
  logic                         window_valid;
  logic                         in_strobe;
  logic        [XW-1:0]         window_x;
  logic        [YW-1:0]         window_y;

  logic signed [SUM_WIDTH-1:0]  sum_out;
  logic                         sum_valid;
  logic        [XW-1:0]         sum_x;
  logic        [YW-1:0]         sum_y;
  logic                         frame_end;
  logic        [CW-1:0]         win_count;

  modport master (
    output window, window_valid, in_strobe, window_x, window_y,
    input  sum_out, sum_valid, sum_x, sum_y, frame_end, win_count
  );

  modport slave (
    input  window, window_valid, in_strobe, window_x, window_y,
    output sum_out, sum_valid, sum_x, sum_y, frame_end, win_count
  );
endinterface

// File: rtl/window_sum_5x5.sv
// Pipelined 25-element signed sum of each accepted 5x5 window, with aligned centre
// coordinates, last-window-of-frame flag and per-frame window count.
module window_sum_5x5 #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int DATA_WIDTH = 12,
  parameter int SUM_WIDTH  = DATA_WIDTH + 5
) (
  input logic             clk,
  input logic             rst_n,
  window_sum_5x5_if.slave bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH * HEIGHT);
  localparam int RW = DATA_WIDTH + 3;

  localparam logic [XW-1:0] LAST_X  = XW'(WIDTH - 3);
  localparam logic [YW-1:0] LAST_Y  = YW'(HEIGHT - 3);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic accept;

  logic                        v0_q, v1_q, v2_q;
  logic [XW-1:0]               x0_q, x1_q, x2_q;
  logic [YW-1:0]               y0_q, y1_q, y2_q;

  logic signed [DATA_WIDTH-1:0] win_q [5][5];
  logic signed [RW-1:0]         row_d [5];
  logic signed [RW-1:0]         row_q [5];
  logic signed [SUM_WIDTH-1:0]  p0_d, p1_d, p0_q, p1_q;
  logic signed [SUM_WIDTH-1:0]  sum_d, sum_q;

  logic                        sum_valid_q;
  logic [XW-1:0]               sum_x_q;
  logic [YW-1:0]               sum_y_q;
  logic                        frame_end_d, frame_end_q;
  logic [CW-1:0]               cnt_d, cnt_q;

  assign accept = bus.window_valid && bus.in_strobe;

  always_comb begin : row_sum
    logic signed [RW-1:0] acc;
    for (int unsigned r = 0; r < 5; r++) begin
      acc = '0;
      for (int unsigned c = 0; c < 5; c++) begin
        acc = acc + RW'(win_q[r][c]);
      end
      row_d[r] = acc;
    end
  end

  always_comb begin
    p0_d  = SUM_WIDTH'(row_q[0]) + SUM_WIDTH'(row_q[1]) + SUM_WIDTH'(row_q[2]);
    p1_d  = SUM_WIDTH'(row_q[3]) + SUM_WIDTH'(row_q[4]);
    sum_d = p0_q + p1_q;
  end

  assign frame_end_d = v2_q && (x2_q == LAST_X) && (y2_q == LAST_Y);

  // The frame_end cycle still shows the pre-window count; the clear replaces that increment.
  always_comb begin
    cnt_d = cnt_q;
    if (sum_valid_q && frame_end_q) begin
      cnt_d = '0;
    end else if (sum_valid_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath stages carry no reset: only the valid bits decide what reaches the outputs.
  always_ff @(posedge clk) begin
    win_q <= bus.window;
    row_q <= row_d;
    p0_q  <= p0_d;
    p1_q  <= p1_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      frame_end_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      v0_q        <= accept;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      x0_q        <= bus.window_x;
      x1_q        <= x0_q;
      x2_q        <= x1_q;
      y0_q        <= bus.window_y;
      y1_q        <= y0_q;
      y2_q        <= y1_q;
      sum_valid_q <= v2_q;
      frame_end_q <= frame_end_d;
      cnt_q       <= cnt_d;
      if (v2_q) begin
        sum_q   <= sum_d;
        sum_x_q <= x2_q;
        sum_y_q <= y2_q;
      end
    end
  end

  assign bus.sum_out   = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum_x     = sum_x_q;
  assign bus.sum_y     = sum_y_q;
  assign bus.frame_end = frame_end_q;
  assign bus.win_count = cnt_q;
endmodule

// File: tb/tb_window_sum_5x5.sv
// Directed bench for window_sum_5x5 on a reduced 16x8 frame with 12-bit elements.
module tb_window_sum_5x5;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int DW = 12;
  localparam int SW = DW + 5;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;
  int   pulses;
  int   exp_cnt;
  int   idx;
  int   t2_exp [4] = '{-51200, 51175, 300, 30700};

  always #5 clk = ~clk;

  window_sum_5x5_if #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .SUM_WIDTH(SW)) bus ();

  window_sum_5x5 #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .SUM_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_all(input int v);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        bus.window[r][c] = DW'(v);
  endtask

  task automatic set_pat(input int p);
    case (p)
      0: set_all(-2048);
      1: set_all(2047);
      2: for (int r = 0; r < 5; r++)
           for (int c = 0; c < 5; c++) bus.window[r][c] = DW'(r * 5 + c);
      default: for (int r = 0; r < 5; r++)
                 for (int c = 0; c < 5; c++) bus.window[r][c] = DW'((r == 4) ? -2048 : 2047);
    endcase
  endtask

  task automatic drive(input logic vld, input logic stb, input int x, input int y);
    bus.window_valid = vld;
    bus.in_strobe    = stb;
    bus.window_x     = XW'(x);
    bus.window_y     = YW'(y);
  endtask

  initial begin
    set_all(0);
    drive(1'b0, 1'b0, 0, 0);
    step();
    chk("rst_valid", bus.sum_valid, 0);
    chk("rst_sum",   bus.sum_out,   0);
    chk("rst_x",     bus.sum_x,     0);
    chk("rst_y",     bus.sum_y,     0);
    chk("rst_fe",    bus.frame_end, 0);
    chk("rst_cnt",   bus.win_count, 0);
    rst_n = 1'b1;

    // single window of ones
    set_all(1);
    drive(1'b1, 1'b1, 5, 3);
    step();
    drive(1'b1, 1'b0, 5, 3);
    step();
    step();
    chk("t1_early", bus.sum_valid, 0);
    step();
    chk("t1_valid", bus.sum_valid, 1);
    chk("t1_sum",   bus.sum_out,   25);
    chk("t1_x",     bus.sum_x,     5);
    chk("t1_y",     bus.sum_y,     3);
    chk("t1_fe",    bus.frame_end, 0);
    chk("t1_cnt",   bus.win_count, 0);
    step();
    chk("t1_pulse", bus.sum_valid, 0);
    chk("t1_hold",  bus.sum_out,   25);
    chk("t1_cnt2",  bus.win_count, 1);

    // extremes and row-partition patterns, back to back
    for (int j = 0; j < 7; j++) begin
      if (j < 4) begin
        set_pat(j);
        drive(1'b1, 1'b1, j, j);
      end else begin
        drive(1'b0, 1'b0, 0, 0);
      end
      step();
      if (j >= 3) begin
        chk("t2_valid", bus.sum_valid, 1);
        chk("t2_sum",   bus.sum_out,   t2_exp[j-3]);
        chk("t2_x",     bus.sum_x,     j - 3);
      end
    end
    step();
    chk("t2_idle", bus.sum_valid, 0);
    chk("t2_cnt",  bus.win_count, 5);

    // strobe without window_valid, then window_valid level with alternate strobes
    set_all(7);
    drive(1'b0, 1'b1, 0, 0);
    step();
    pulses = 0;
    for (int j = 0; j < 14; j++) begin
      if (j < 10) begin
        set_all(j + 1);
        drive(1'b1, (j % 2) == 0, j, 0);
      end else begin
        drive(1'b0, 1'b0, 0, 0);
      end
      step();
      if (bus.sum_valid === 1'b1) pulses++;
      if (j >= 3 && j <= 11 && ((j - 3) % 2) == 0) begin
        chk("t3_valid", bus.sum_valid, 1);
        chk("t3_sum",   bus.sum_out,   25 * (j - 2));
      end else begin
        chk("t3_gap", bus.sum_valid, 0);
      end
    end
    chk("t3_pulses", pulses, 5);
    chk("t3_cnt",    bus.win_count, 10);

    // eight consecutive accepts
    for (int j = 0; j < 11; j++) begin
      if (j < 8) begin
        set_all(j + 1);
        drive(1'b1, 1'b1, j + 1, j);
      end else begin
        drive(1'b0, 1'b0, 0, 0);
      end
      step();
      if (j >= 3) begin
        chk("t4_valid", bus.sum_valid, 1);
        chk("t4_sum",   bus.sum_out,   25 * (j - 2));
        chk("t4_x",     bus.sum_x,     j - 2);
        chk("t4_y",     bus.sum_y,     j - 3);
        chk("t4_cnt",   bus.win_count, 10 + (j - 3));
      end
    end
    step();
    chk("t4_idle", bus.sum_valid, 0);
    chk("t4_cnt2", bus.win_count, 18);

    // reset with windows in flight
    set_all(3);
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b1, 1, 1);
      step();
    end
    drive(1'b0, 1'b0, 0, 0);
    step();
    chk("t6_pre_valid", bus.sum_valid, 1);
    chk("t6_pre_sum",   bus.sum_out,   75);
    chk("t6_pre_cnt",   bus.win_count, 18);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", bus.sum_valid, 0);
    chk("t6_sum",   bus.sum_out,   0);
    chk("t6_x",     bus.sum_x,     0);
    chk("t6_y",     bus.sum_y,     0);
    chk("t6_fe",    bus.frame_end, 0);
    chk("t6_cnt",   bus.win_count, 0);
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("t6_flush", bus.sum_valid, 0);
    end
    set_all(4);
    drive(1'b1, 1'b1, 2, 2);
    step();
    drive(1'b0, 1'b0, 0, 0);
    step();
    step();
    chk("t6_early", bus.sum_valid, 0);
    step();
    chk("t6_new_valid", bus.sum_valid, 1);
    chk("t6_new_sum",   bus.sum_out,   100);
    chk("t6_new_x",     bus.sum_x,     2);
    chk("t6_new_y",     bus.sum_y,     2);
    chk("t6_new_cnt",   bus.win_count, 0);
    step();
    chk("t6_new_cnt2",  bus.win_count, 1);

    // full reduced frame: centres x 2..13, y 2..5
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    pulses = 0;
    for (int j = 0; j < 52; j++) begin
      if (j < 48) begin
        set_all((j % 7) - 3);
        drive(1'b1, 1'b1, 2 + (j % 12), 2 + (j / 12));
      end else begin
        drive(1'b0, 1'b0, 0, 0);
      end
      step();
      if (bus.frame_end === 1'b1) pulses++;
      if (j >= 3) begin
        idx = j - 3;
        if (idx < 48) begin
          chk("t5_valid", bus.sum_valid, 1);
          chk("t5_fe",    bus.frame_end, idx == 47);
          chk("t5_cnt",   bus.win_count, idx);
          if ((idx % 12) == 0 || idx == 47) begin
            chk("t5_sum", bus.sum_out, 25 * ((idx % 7) - 3));
            chk("t5_x",   bus.sum_x,   2 + (idx % 12));
            chk("t5_y",   bus.sum_y,   2 + (idx / 12));
          end
        end else begin
          chk("t5_idle",   bus.sum_valid, 0);
          chk("t5_fe_off", bus.frame_end, 0);
          chk("t5_cnt0",   bus.win_count, 0);
        end
      end
    end
    chk("t5_fe_pulses", pulses, 1);

    // count saturates at its 7-bit maximum
    set_all(0);
    for (int j = 0; j < 134; j++) begin
      if (j < 130) drive(1'b1, 1'b1, 0, 0);
      else         drive(1'b0, 1'b0, 0, 0);
      step();
      exp_cnt = (j < 3) ? 0 : (j - 3);
      if (exp_cnt > 127) exp_cnt = 127;
      chk("sat_cnt", bus.win_count, exp_cnt);
      chk("sat_fe",  bus.frame_end, 0);
    end
    chk("sat_final", bus.win_count, 127);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
